// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: shared FSM states, requester indices, page numbers and lane helper
// for the config memory access arbiter.
package cfg_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    localparam logic [1:0] REQ_SPI  = 2'd0;
    localparam logic [1:0] REQ_UART = 2'd1;
    localparam logic [1:0] REQ_PROC = 2'd2;

    localparam logic [7:0] STATUS_PAGE_DEF = 8'd1;
    localparam logic [7:0] PROC_PAGE_DEF   = 8'd4;

    // {found, lane} of the lowest enabled lane at or above start; be[3] is lane 0
    function automatic logic [2:0] next_lane(input logic [3:0] be, input logic [2:0] start);
        next_lane = 3'b000;
        for (int l = 3; l >= 0; l--)
            if (l >= int'(start) && be[3-l]) next_lane = {1'b1, 2'(l)};
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: three-way round-robin grant; the pointer remembers the last grantee
// and resets to the processor so the first order is spi, uart, proc.
module rr_arb3
    import cfg_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic [2:0] req,
    input  logic       take,
    output logic       gnt_vld,
    output logic [1:0] gnt_idx
);

    logic [1:0] last_q, last_d, c1, c2;

    always_comb begin
        c1      = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        c2      = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        gnt_vld = |req;
        gnt_idx = req[c1] ? c1 : req[c2] ? c2 : last_q;
        last_d  = (take && gnt_vld) ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) last_q <= REQ_PROC;
        else        last_q <= last_d;

endmodule

// File: rtl/config_access_arb.sv
// config_access_arb: serialises spi/uart/proc config accesses onto one byte port.
// Define CFG_ARB_PAGE_CHECK_EN to suppress and count illegal page accesses.
module config_access_arb
    import cfg_arb_pkg::*;
#(
    parameter logic [7:0] STATUS_PAGE = STATUS_PAGE_DEF,
    parameter logic [7:0] PROC_PAGE   = PROC_PAGE_DEF,
    parameter int         ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 spi_req,
    input  logic                 spi_we,
    input  logic [11:0]          spi_adr,
    input  logic [7:0]           spi_wdata,
    output logic                 spi_ack,
    output logic [7:0]           spi_rdata,
    input  logic                 uart_req,
    input  logic                 uart_we,
    input  logic [7:0]           uart_page,
    input  logic [7:0]           uart_offset,
    input  logic [7:0]           uart_wdata,
    input  logic [7:0]           uart_wmsk,
    output logic                 uart_ack,
    output logic [7:0]           uart_rdata,
    input  logic                 proc_req,
    input  logic                 proc_we,
    input  logic [3:0]           proc_be,
    input  logic [13:0]          proc_addr,
    input  logic [31:0]          proc_wdata,
    output logic                 proc_ack,
    output logic [31:0]          proc_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [7:0]           mem_page,
    output logic [7:0]           mem_offset,
    output logic [7:0]           mem_wdata,
    output logic [7:0]           mem_wmsk,
    input  logic [7:0]           mem_rdata,
    output logic [ERR_CNT_W-1:0] access_err
);

`ifdef CFG_ARB_PAGE_CHECK_EN
    localparam bit PAGE_CHECK = 1'b1;
`else
    localparam bit PAGE_CHECK = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [1:0]             gnt_q, gnt_d, lane_q, lane_d, gnt_idx;
    logic                   we_q, we_d, sup_q, sup_d, gnt_vld, take, done, rd_ok;
    logic [7:0]             page_q, page_d, off_q, off_d, wmsk_q, wmsk_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [23:0]            rd_q, rd_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic                   c_we, c_sup;
    logic [7:0]             c_page, c_off, c_wmsk;
    logic [31:0]            c_wdata;
    logic [3:0]             c_be;
    logic [2:0]             c_first, nl;

    rr_arb3 u_rr (
        .clk     (clk),
        .rst_b   (rst_b),
        .req     ({proc_req, uart_req, spi_req}),
        .take    (take),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Normalise the winning request; byte requesters ride on lane 0 only
    always_comb begin
        c_we    = spi_we;
        c_page  = {4'h0, spi_adr[11:8]};
        c_off   = spi_adr[7:0];
        c_wdata = {spi_wdata, 24'h0};
        c_wmsk  = 8'hFF;
        c_be    = 4'b1000;
        if (gnt_idx == REQ_UART) begin
            c_we    = uart_we;
            c_page  = uart_page;
            c_off   = uart_offset;
            c_wdata = {uart_wdata, 24'h0};
            c_wmsk  = uart_wmsk;
        end else if (gnt_idx == REQ_PROC) begin
            c_we    = proc_we;
            c_page  = proc_addr[13:6];
            c_off   = {proc_addr[5:0], 2'b00};
            c_wdata = proc_wdata;
            c_be    = proc_we ? proc_be : 4'hF;
        end
        c_sup   = PAGE_CHECK && !(c_page == 8'd0 || c_page == PROC_PAGE ||
                                  (c_page == STATUS_PAGE && !c_we));
        c_first = next_lane(c_be, 3'd0);
    end

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        nl      = next_lane(be_q, {1'b0, lane_q} + 3'd1);
        if (state_q == IDLE && gnt_vld) begin
            take    = 1'b1;
            state_d = c_first[2] ? ISSUE : DONE;
        end else if (state_q == ISSUE) begin
            state_d = nl[2] ? ISSUE : DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // Read bytes arrive one cycle after their issue; lanes 0..2 are shifted in
    // while later lanes are still issuing, lane 3 is taken live in DONE
    always_comb begin
        gnt_d   = take ? gnt_idx : gnt_q;
        we_d    = take ? c_we : we_q;
        page_d  = take ? c_page : page_q;
        off_d   = take ? c_off : off_q;
        wdata_d = take ? c_wdata : wdata_q;
        wmsk_d  = take ? c_wmsk : wmsk_q;
        be_d    = take ? c_be : be_q;
        sup_d   = take ? c_sup : sup_q;
        lane_d  = take ? c_first[1:0] : (state_q == ISSUE && nl[2]) ? nl[1:0] : lane_q;
        rd_d    = (state_q == ISSUE && !we_q && lane_q != 2'd0) ? {rd_q[15:0], mem_rdata} : rd_q;
        err_d   = (take && c_sup && !(&err_q)) ? err_q + ERR_CNT_W'(1) : err_q;
    end

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            gnt_q   <= REQ_SPI;
            we_q    <= 1'b0;
            page_q  <= 8'h0;
            off_q   <= 8'h0;
            wdata_q <= 32'h0;
            wmsk_q  <= 8'h0;
            be_q    <= 4'h0;
            sup_q   <= 1'b0;
            lane_q  <= 2'd0;
            rd_q    <= 24'h0;
            err_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            page_q  <= page_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            wmsk_q  <= wmsk_d;
            be_q    <= be_d;
            sup_q   <= sup_d;
            lane_q  <= lane_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end

    always_comb begin
        mem_en     = (state_q == ISSUE) && !sup_q;
        mem_we     = mem_en && we_q;
        mem_page   = mem_en ? page_q : 8'h0;
        mem_offset = mem_en ? (off_q | {6'h0, lane_q}) : 8'h0;
        mem_wdata  = mem_en ? 8'(wdata_q >> {~lane_q, 3'b000}) : 8'h0;
        mem_wmsk   = mem_en ? wmsk_q : 8'h0;
        done       = (state_q == DONE);
        spi_ack    = done && gnt_q == REQ_SPI;
        uart_ack   = done && gnt_q == REQ_UART;
        proc_ack   = done && gnt_q == REQ_PROC;
        rd_ok      = done && !we_q && !sup_q;
        spi_rdata  = (spi_ack && rd_ok) ? mem_rdata : 8'h0;
        uart_rdata = (uart_ack && rd_ok) ? mem_rdata : 8'h0;
        proc_rdata = (proc_ack && rd_ok) ? {rd_q, mem_rdata} : 32'h0;
        access_err = err_q;
    end

endmodule

// File: tb/tb_config_access_arb.sv
// tb_config_access_arb: directed and random requester traffic against a
// transaction-level schedule model plus a byte memory behind the DUT.
module tb_config_access_arb;

`ifdef CFG_ARB_PAGE_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic        clk = 1'b0, rst_b = 1'b0;
    logic        spi_req = 1'b0, spi_we = 1'b0;
    logic [11:0] spi_adr = '0;
    logic [7:0]  spi_wdata = '0, spi_rdata;
    logic        spi_ack;
    logic        uart_req = 1'b0, uart_we = 1'b0, uart_ack;
    logic [7:0]  uart_page = '0, uart_offset = '0, uart_wdata = '0, uart_wmsk = '0, uart_rdata;
    logic        proc_req = 1'b0, proc_we = 1'b0, proc_ack;
    logic [3:0]  proc_be = '0;
    logic [13:0] proc_addr = '0;
    logic [31:0] proc_wdata = '0, proc_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_page, mem_offset, mem_wdata, mem_wmsk, access_err;
    logic [7:0]  mem_rdata = 8'h00;

    int cyc = 0, vectors = 0, miscompares = 0;

    config_access_arb dut (
        .clk(clk), .rst_b(rst_b),
        .spi_req(spi_req), .spi_we(spi_we), .spi_adr(spi_adr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_page(uart_page), .uart_offset(uart_offset),
        .uart_wdata(uart_wdata), .uart_wmsk(uart_wmsk), .uart_ack(uart_ack), .uart_rdata(uart_rdata),
        .proc_req(proc_req), .proc_we(proc_we), .proc_be(proc_be), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_ack(proc_ack), .proc_rdata(proc_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_page(mem_page), .mem_offset(mem_offset),
        .mem_wdata(mem_wdata), .mem_wmsk(mem_wmsk), .mem_rdata(mem_rdata), .access_err(access_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Unwritten bytes read back as a fixed function of their address
    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37) ^ (a >> 8));
    endfunction

    logic [7:0] env_mem [int];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] env_rd(input int a);
        return env_mem.exists(a) ? env_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    int env_a;
    always @(posedge clk)
        if (rst_b && mem_en) begin
            env_a = int'({mem_page, mem_offset});
            if (mem_we) env_mem[env_a] = (env_rd(env_a) & ~mem_wmsk) | (mem_wdata & mem_wmsk);
            else        mem_rdata <= env_rd(env_a);
        end

    // Transaction model: each grant schedules its memory ops and ack by cycle number
    typedef struct {logic we; logic [7:0] page, off, wdata, wmsk;} op_t;
    op_t         exp_op [int];
    op_t         o;
    int          ack_at [3] = '{-1, -1, -1};
    logic [31:0] exp_rd [3];
    logic        exp_rdchk [3];
    int          busy_end = 0, last_m = 2, err_m = 0, win, t, ma;
    logic [2:0]  pend, acks;
    logic        g_we, sup;
    logic [7:0]  g_page, g_off, g_msk, lb;
    logic [31:0] g_wd, rd, rdv;
    logic [3:0]  g_be;

    always @(negedge clk)
        if (rst_b) begin
            acks = {proc_ack, uart_ack, spi_ack};
            check("mem_en", mem_en, exp_op.exists(cyc));
            if (mem_en && exp_op.exists(cyc)) begin
                o = exp_op[cyc];
                check("mem_we", mem_we, o.we);
                check("mem_page", mem_page, o.page);
                check("mem_offset", mem_offset, o.off);
                if (o.we) begin
                    check("mem_wdata", mem_wdata, o.wdata);
                    check("mem_wmsk", mem_wmsk, o.wmsk);
                end
            end
            if (exp_op.exists(cyc)) exp_op.delete(cyc);
            for (int r = 0; r < 3; r++) begin
                check($sformatf("ack_req%0d", r), acks[r], ack_at[r] == cyc);
                if (acks[r] && ack_at[r] == cyc && exp_rdchk[r]) begin
                    rdv = (r == 0) ? {24'h0, spi_rdata} : (r == 1) ? {24'h0, uart_rdata} : proc_rdata;
                    check($sformatf("rdata_req%0d", r), rdv, exp_rd[r]);
                end
            end
            check("access_err", access_err, err_m);
            pend = {proc_req, uart_req, spi_req};
            win = -1;
            if (cyc >= busy_end)
                for (int k = 1; k <= 3; k++)
                    if (win < 0 && pend[(last_m + k) % 3]) win = (last_m + k) % 3;
            if (win >= 0) begin
                g_msk = 8'hFF;
                g_be  = 4'b1000;
                if (win == 0) begin
                    g_we = spi_we; g_page = {4'h0, spi_adr[11:8]}; g_off = spi_adr[7:0];
                    g_wd = {spi_wdata, 24'h0};
                end else if (win == 1) begin
                    g_we = uart_we; g_page = uart_page; g_off = uart_offset;
                    g_wd = {uart_wdata, 24'h0}; g_msk = uart_wmsk;
                end else begin
                    g_we = proc_we; g_page = proc_addr[13:6]; g_off = {proc_addr[5:0], 2'b00};
                    g_wd = proc_wdata; g_be = proc_we ? proc_be : 4'hF;
                end
                sup = PC && !(g_page == 8'd0 || g_page == 8'd4 || (g_page == 8'd1 && !g_we));
                if (sup && err_m < 255) err_m++;
                t  = cyc + 1;
                rd = 32'h0;
                for (int l = 0; l < 4; l++)
                    if (g_be[3-l]) begin
                        ma = int'({g_page, g_off + 8'(l)});
                        lb = g_wd[31-8*l -: 8];
                        if (!sup) begin
                            exp_op[t] = '{g_we, g_page, g_off + 8'(l), lb, g_msk};
                            if (g_we) ref_mem[ma] = (ref_rd(ma) & ~g_msk) | (lb & g_msk);
                            else      rd[31-8*l -: 8] = ref_rd(ma);
                        end
                        t++;
                    end
                ack_at[win]    = t;
                exp_rd[win]    = (win == 2) ? rd : {24'h0, rd[31:24]};
                exp_rdchk[win] = !g_we;
                busy_end       = t + 1;
                last_m         = win;
            end
        end

    task automatic spi_txn(input logic we, input logic [11:0] adr, input logic [7:0] wd,
                           output logic [7:0] rdo, output int lat);
        int st = cyc;
        logic got = 1'b0;
        spi_req = 1'b1; spi_we = we; spi_adr = adr; spi_wdata = wd;
        for (int n = 0; n < 200 && !got; n++) begin @(negedge clk); got = spi_ack; end
        check("spi_ack_seen", got, 1'b1);
        rdo = spi_rdata; lat = cyc - st;
        @(posedge clk); #1; spi_req = 1'b0;
    endtask

    task automatic uart_txn(input logic we, input logic [7:0] pg, input logic [7:0] off,
                            input logic [7:0] wd, input logic [7:0] msk,
                            output logic [7:0] rdo, output int lat);
        int st = cyc;
        logic got = 1'b0;
        uart_req = 1'b1; uart_we = we; uart_page = pg; uart_offset = off;
        uart_wdata = wd; uart_wmsk = msk;
        for (int n = 0; n < 200 && !got; n++) begin @(negedge clk); got = uart_ack; end
        check("uart_ack_seen", got, 1'b1);
        rdo = uart_rdata; lat = cyc - st;
        @(posedge clk); #1; uart_req = 1'b0;
    endtask

    task automatic proc_txn(input logic we, input logic [13:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rdo, output int lat);
        int st = cyc;
        logic got = 1'b0;
        proc_req = 1'b1; proc_we = we; proc_addr = addr; proc_be = be; proc_wdata = wd;
        for (int n = 0; n < 200 && !got; n++) begin @(negedge clk); got = proc_ack; end
        check("proc_ack_seen", got, 1'b1);
        rdo = proc_rdata; lat = cyc - st;
        @(posedge clk); #1; proc_req = 1'b0;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    endtask

    task automatic spi_rand(input int n);
        logic [3:0]  pg [4] = '{4'd0, 4'd1, 4'd4, 4'd2};
        logic [7:0]  r8;
        int          lat;
        for (int i = 0; i < n; i++) begin
            idle_gap();
            spi_txn(1'($urandom), {pg[$urandom_range(0, 3)], 4'h0, 4'($urandom)},
                    8'($urandom), r8, lat);
        end
    endtask

    task automatic uart_rand(input int n);
        logic [7:0]  pg [4] = '{8'd0, 8'd1, 8'd4, 8'd7};
        logic [7:0]  r8;
        int          lat;
        for (int i = 0; i < n; i++) begin
            idle_gap();
            uart_txn(1'($urandom), pg[$urandom_range(0, 3)], {4'h0, 4'($urandom)},
                     8'($urandom), 8'($urandom), r8, lat);
        end
    endtask

    task automatic proc_rand(input int n);
        logic [7:0]  pg [4] = '{8'd0, 8'd1, 8'd4, 8'd9};
        logic [31:0] r32;
        int          lat;
        for (int i = 0; i < n; i++) begin
            idle_gap();
            proc_txn(1'($urandom), {pg[$urandom_range(0, 3)], 4'h0, 2'($urandom)},
                     4'($urandom), $urandom, r32, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 50000", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0]  r8, r8b, b0d, b0f;
        logic [31:0] r32;
        int          l0, l1, l2;
        repeat (3) @(negedge clk);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_page", {mem_page, mem_offset, mem_wdata, mem_wmsk}, 32'h0);
        check("rst_acks", {spi_ack, uart_ack, proc_ack}, 3'b000);
        check("rst_rdata", proc_rdata | {uart_rdata, spi_rdata}, 32'h0);
        check("rst_access_err", access_err, 8'h0);
        @(posedge clk); #1; rst_b = 1'b1;
        @(posedge clk); #1;

        fork
            spi_txn(1'b0, 12'h011, 8'h00, r8, l0);
            uart_txn(1'b0, 8'h00, 8'h12, 8'h00, 8'h00, r8b, l1);
            proc_txn(1'b0, 14'h005, 4'h0, 32'h0, r32, l2);
        join
        check("rr_spi_lat", l0, 2);
        check("rr_uart_lat", l1, 5);
        check("rr_proc_lat", l2, 11);

        spi_txn(1'b1, 12'h010, 8'hA5, r8, l0);
        check("spi_wr_lat", l0, 2);
        spi_txn(1'b0, 12'h010, 8'h00, r8, l0);
        check("spi_rd_lat", l0, 2);
        check("spi_rd_data", r8, 8'hA5);

        b0d = env_rd(16'h000D);
        b0f = env_rd(16'h000F);
        proc_txn(1'b1, 14'h003, 4'b1010, 32'h11223344, r32, l0);
        check("pw_lat", l0, 3);
        check("pw_lane0", env_rd(16'h000C), 8'h11);
        check("pw_lane2", env_rd(16'h000E), 8'h33);
        check("pw_lane1_kept", env_rd(16'h000D), b0d);
        check("pw_lane3_kept", env_rd(16'h000F), b0f);

        proc_txn(1'b1, 14'h004, 4'b0000, 32'hFFFFFFFF, r32, l0);
        check("pw_be0_lat", l0, 1);

        uart_txn(1'b1, 8'h04, 8'h00, 8'hDE, 8'hFF, r8, l0);
        uart_txn(1'b1, 8'h04, 8'h01, 8'hAD, 8'hFF, r8, l0);
        uart_txn(1'b1, 8'h04, 8'h02, 8'hBE, 8'hFF, r8, l0);
        uart_txn(1'b1, 8'h04, 8'h03, 8'hEF, 8'hFF, r8, l0);
        proc_txn(1'b0, 14'h100, 4'h0, 32'h0, r32, l0);
        check("pr_lat", l0, 5);
        check("pr_data", r32, 32'hDEADBEEF);

        uart_txn(1'b1, 8'h00, 8'h20, 8'h0F, 8'hFF, r8, l0);
        uart_txn(1'b1, 8'h00, 8'h20, 8'hF0, 8'h3C, r8, l0);
        check("uart_msk_lat", l0, 2);
        uart_txn(1'b0, 8'h00, 8'h20, 8'h00, 8'h00, r8, l0);
        check("uart_msk_rd", r8, 8'h33);

        spi_txn(1'b1, 12'h130, 8'hC3, r8, l0);
        check("pc_spi_lat", l0, 2);
        uart_txn(1'b0, 8'h07, 8'h55, 8'h00, 8'h00, r8, l1);
        check("pc_uart_lat", l1, 2);
        if (PC) begin
            check("pc_uart_rd", r8, 8'h00);
            check("pc_spi_blocked", env_rd(16'h0130), init_byte(16'h0130));
            check("pc_err_cnt", access_err, 8'd2);
        end else begin
            check("pc_uart_rd", r8, init_byte(16'h0755));
            check("pc_spi_written", env_rd(16'h0130), 8'hC3);
            check("pc_err_cnt", access_err, 8'd0);
        end

        fork
            spi_rand(120);
            uart_rand(120);
            proc_rand(120);
        join
        repeat (8) @(negedge clk);
        check("exp_op_drained", exp_op.num(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
